// File: rtl/diff_dot_if.sv
// Beat-stream and result handshake bundle for the differential dot-product engine.
// The master side feeds beats and consumes results; the slave side is the engine.
interface diff_dot_if #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned VEC_LEN  = 128
);
    localparam int unsigned CNT_W = $clog2(VEC_LEN + 1);

    logic                        start;
    logic                        diff_en;
    logic [ACC_W-1:0]            base_in;
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_W-1:0]     in_delta;
    logic [LANES*WEIGHT_W-1:0]   in_weight;
    logic                        out_valid;
    logic                        out_ready;
    logic [ACC_W-1:0]            out_result;
    logic                        out_sat;
    logic [CNT_W-1:0]            outlier_cnt;

    modport master (
        output start, diff_en, base_in, in_valid, in_delta, in_weight, out_ready,
        input  in_ready, out_valid, out_result, out_sat, outlier_cnt
    );

    modport slave (
        input  start, diff_en, base_in, in_valid, in_delta, in_weight, out_ready,
        output in_ready, out_valid, out_result, out_sat, outlier_cnt
    );
endinterface

// File: rtl/diff_dot_engine.sv
// Streaming differential dot product: inlier lanes summed in parallel each beat, outlier lanes
// serialised one per cycle through a single wide multiplier, optional base added at the end.
module diff_dot_engine #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned INLIER_W = 8,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned VEC_LEN  = 128
) (
    input logic       clk,
    input logic       rst,
    diff_dot_if.slave bus
);
    localparam int unsigned BEATS   = VEC_LEN / LANES;
    localparam int unsigned BEAT_W  = $clog2(BEATS + 1);
    localparam int unsigned CNT_W   = $clog2(VEC_LEN + 1);
    localparam int unsigned LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PROD_W  = DATA_W + WEIGHT_W;
    localparam int unsigned IPROD_W = INLIER_W + WEIGHT_W;
    localparam int unsigned SUM_W   = IPROD_W + $clog2(LANES);
    localparam int unsigned EXT_W   = ACC_W + PROD_W + 1;

    localparam logic signed [EXT_W-1:0] ACC_MAX_X = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN_X = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StOutl, StDone} state_e;

    // Returns {clamped, value}; the sum is formed wide enough that it can never wrap.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [EXT_W-1:0] b);
        logic signed [EXT_W-1:0] s;
        s = EXT_W'(a) + b;
        if (s > ACC_MAX_X) return {1'b1, ACC_MAX_X[ACC_W-1:0]};
        if (s < ACC_MIN_X) return {1'b1, ACC_MIN_X[ACC_W-1:0]};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    state_e                      state_q, state_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d, base_q, base_d, result_q, result_d;
    logic                        diff_en_q, diff_en_d, sat_q, sat_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [LANES-1:0]            mask_q, mask_d;
    logic [LANES*DATA_W-1:0]     od_q, od_d;
    logic [LANES*WEIGHT_W-1:0]   ow_q, ow_d;

    logic signed [SUM_W-1:0]     lane_sum;
    logic [LANES-1:0]            mask_in;
    logic [DATA_W-1:0]           lane_d;
    logic signed [WEIGHT_W-1:0]  lane_w;
    logic signed [IPROD_W-1:0]   iprod;

    // Narrow path: a lane is inlier when its top DATA_W-INLIER_W+1 bits are a pure sign run.
    always_comb begin
        lane_sum = '0;
        mask_in  = '0;
        lane_d   = '0;
        lane_w   = '0;
        iprod    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_d = bus.in_delta[i*DATA_W +: DATA_W];
            lane_w = bus.in_weight[i*WEIGHT_W +: WEIGHT_W];
            if ((&lane_d[DATA_W-1:INLIER_W-1]) || !(|lane_d[DATA_W-1:INLIER_W-1])) begin
                iprod    = $signed(lane_d[INLIER_W-1:0]) * lane_w;
                lane_sum = lane_sum + SUM_W'(iprod);
            end else begin
                mask_in[i] = 1'b1;
            end
        end
    end

    logic [LANE_W-1:0]           sel;
    logic signed [DATA_W-1:0]    o_d;
    logic signed [WEIGHT_W-1:0]  o_w;
    logic signed [PROD_W-1:0]    oprod;
    logic [LANES-1:0]            mask_clr;

    always_comb begin
        sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_q[i]) sel = LANE_W'(i);
        end
        o_d      = od_q[int'(sel)*DATA_W +: DATA_W];
        o_w      = ow_q[int'(sel)*WEIGHT_W +: WEIGHT_W];
        oprod    = o_d * o_w;
        mask_clr = mask_q & ~(LANES'(1) << sel);
    end

    logic signed [EXT_W-1:0]     addend;
    logic [ACC_W:0]              acc_sum, fin;
    logic                        finish;

    always_comb begin
        addend    = (state_q == StOutl) ? EXT_W'(oprod) : EXT_W'(lane_sum);
        acc_sum   = sat_add(acc_q, addend);
        fin       = sat_add(acc_sum[ACC_W-1:0], EXT_W'(base_q));
        finish    = 1'b0;
        state_d   = state_q;
        acc_d     = acc_q;
        base_d    = base_q;
        diff_en_d = diff_en_q;
        sat_d     = sat_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        od_d      = od_q;
        ow_d      = ow_q;
        result_d  = result_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StAccum;
                    acc_d     = '0;
                    base_d    = bus.base_in;
                    diff_en_d = bus.diff_en;
                    sat_d     = 1'b0;
                    beat_d    = '0;
                    cnt_d     = '0;
                    mask_d    = '0;
                end
            end
            StAccum: begin
                if (bus.in_valid) begin
                    acc_d  = acc_sum[ACC_W-1:0];
                    sat_d  = sat_q | acc_sum[ACC_W];
                    beat_d = beat_q + BEAT_W'(1);
                    mask_d = mask_in;
                    od_d   = bus.in_delta;
                    ow_d   = bus.in_weight;
                    if (mask_in != '0) begin
                        state_d = StOutl;
                    end else if (beat_q == BEAT_W'(BEATS - 1)) begin
                        finish = 1'b1;
                    end
                end
            end
            StOutl: begin
                acc_d  = acc_sum[ACC_W-1:0];
                sat_d  = sat_q | acc_sum[ACC_W];
                mask_d = mask_clr;
                cnt_d  = cnt_q + CNT_W'(1);
                if (mask_clr == '0) begin
                    if (beat_q == BEAT_W'(BEATS)) finish = 1'b1;
                    else                          state_d = StAccum;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Result is taken from the final accumulation of this same edge, so no extra cycle.
        if (finish) begin
            state_d  = StDone;
            result_d = diff_en_q ? fin[ACC_W-1:0] : acc_sum[ACC_W-1:0];
            sat_d    = sat_q | acc_sum[ACC_W] | (diff_en_q & fin[ACC_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            base_q    <= '0;
            diff_en_q <= 1'b0;
            sat_q     <= 1'b0;
            beat_q    <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            od_q      <= '0;
            ow_q      <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            base_q    <= base_d;
            diff_en_q <= diff_en_d;
            sat_q     <= sat_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            od_q      <= od_d;
            ow_q      <= ow_d;
            result_q  <= result_d;
        end
    end

    assign bus.in_ready    = (state_q == StAccum);
    assign bus.out_valid   = (state_q == StDone);
    assign bus.out_result  = result_q;
    assign bus.out_sat     = sat_q;
    assign bus.outlier_cnt = cnt_q;
endmodule
